// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - eight-phase instruction sequencer for a simple accumulator CPU
//
// Purpose: steps P0..P7 (INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR,
// OP_FETCH, ALU_OP, STORE) once per clock and decodes the datapath control
// strobes from the current phase, opcode and accumulator-zero flag. HLT parks
// the sequencer in HALTED.
//
// Optional feature macro: CTRL_RESUME_EN adds a resume input that lets HALTED
// return to P0; without it HALTED exits only through rst_n.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   resume  in   leave HALTED (only with CTRL_RESUME_EN)
//   opcode  in   [2:0] instruction opcode
//   zero    in   accumulator-zero flag
//   sel     out  address mux select, 1=PC, 0=IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load
//   ld_ac   out  accumulator load
//   wr      out  memory write strobe
//   data_e  out  accumulator-to-bus drive enable
//   halt    out  processor halted
//   phase   out  [2:0] current phase index, 0 while HALTED

module ctrl_seq (
    input  logic       clk,
    input  logic       rst_n,
`ifdef CTRL_RESUME_EN
    input  logic       resume,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Phase states use their phase index as the low three bits so the debug
    // phase output is a plain slice.
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t state_q;
    state_t state_d;

    logic alu_op;
    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt = (opcode == OP_HLT);
    assign is_skz = (opcode == OP_SKZ);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INST_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INST_ADDR:  state_d = S_INST_FETCH;
            S_INST_FETCH: state_d = S_INST_LOAD;
            S_INST_LOAD:  state_d = S_IDLE;
            S_IDLE:       state_d = S_OP_ADDR;
            S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   state_d = S_ALU_OP;
            S_ALU_OP:     state_d = S_STORE;
            S_STORE:      state_d = S_INST_ADDR;
            S_HALTED: begin
`ifdef CTRL_RESUME_EN
                if (resume) begin
                    state_d = S_INST_ADDR;
                end
`else
                state_d = S_HALTED;
`endif
            end
            default:      state_d = S_INST_ADDR;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (state_q)
            S_INST_ADDR: begin
                sel = 1'b1;
            end
            S_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                // The PC advances past the instruction even for HLT.
                inc_pc = 1'b1;
                halt   = is_hlt;
            end
            S_OP_FETCH: begin
                rd = alu_op;
            end
            S_ALU_OP: begin
                rd     = alu_op;
                inc_pc = is_skz & zero;
                ld_pc  = is_jmp;
                data_e = is_sto;
            end
            S_STORE: begin
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = is_jmp;
                wr     = is_sto;
                data_e = is_sto;
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    assign phase = (state_q == S_HALTED) ? 3'd0 : state_q[2:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - self-checking bench for ctrl_seq against a phase-counter reference model

module tb_ctrl_seq;

    logic       clk;
    logic       rst_n;
`ifdef CTRL_RESUME_EN
    logic       resume;
`endif
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model: an integer phase counter plus a halted flag.
    int m_phase = 0;
    bit m_halt  = 0;

    ctrl_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef CTRL_RESUME_EN
        .resume (resume),
`endif
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} from the phase table.
    function automatic logic [8:0] exp_out(int ph, bit hl, logic [2:0] op, logic z);
        bit s, r, li, ip, lp, la, w, de, h;
        bit alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        {s, r, li, ip, lp, la, w, de, h} = 9'd0;
        if (hl) begin
            h = 1;
        end else begin
            if (ph <= 3) s = 1;
            if (ph >= 1 && ph <= 3) r = 1;
            if (ph == 2 || ph == 3) li = 1;
            if (ph == 4) begin
                ip = 1;
                h  = (op == 3'd0);
            end
            if (ph >= 5) r = alu;
            if (ph == 6) begin
                ip = (op == 3'd1) && z;
                lp = (op == 3'd7);
                de = (op == 3'd6);
            end
            if (ph == 7) begin
                la = alu;
                lp = (op == 3'd7);
                w  = (op == 3'd6);
                de = (op == 3'd6);
            end
        end
        return {s, r, li, ip, lp, la, w, de, h};
    endfunction

    // One clock: model advances with the inputs present at the edge; returns at edge+2.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            if (m_halt) begin
`ifdef CTRL_RESUME_EN
                if (resume) begin
                    m_halt  = 0;
                    m_phase = 0;
                end
`endif
            end else if (m_phase == 4 && opcode == 3'd0) begin
                m_halt = 1;
            end else begin
                m_phase = (m_phase + 1) % 8;
            end
        end
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_phase = 0;
        m_halt = 0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        opcode = 3'd2;
        zero = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 9'b100000000 || phase !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b phase %0d, want 100000000 phase 0", obs, phase);
        end
        rst_n = 1'b1;
        m_phase = 0;
        m_halt = 0;
        cycle();
        #1;
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_edge: got phase %0d, want 1", phase);
        end
    endtask

    // Runs one full instruction from P0 and returns per-phase masks of selected strobes.
    task automatic run_instr(input logic [2:0] op, input logic z, input string nm,
                             output logic [7:0] m_inc, output logic [7:0] m_rd,
                             output logic [7:0] m_ldac, output logic [7:0] m_ldpc,
                             output logic [7:0] m_wr, output logic [7:0] m_de);
        m_inc = 0; m_rd = 0; m_ldac = 0; m_ldpc = 0; m_wr = 0; m_de = 0;
        do_reset();
        opcode = op;
        zero = z;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (phase !== 3'(i) || obs !== exp_out(m_phase, m_halt, opcode, zero)) begin
                errors++;
                $display("FAIL %s_p%0d: got %b phase %0d, want %b phase %0d", nm, i, obs, phase,
                         exp_out(m_phase, m_halt, opcode, zero), i);
            end
            m_inc[i] = inc_pc; m_rd[i] = rd; m_ldac[i] = ld_ac;
            m_ldpc[i] = ld_pc; m_wr[i] = wr; m_de[i] = data_e;
            cycle();
        end
        #1;
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL %s_wrap: got phase %0d, want 0", nm, phase);
        end
    endtask

    task automatic test_add();
        logic [7:0] mi, mr, ma, mp, mw, md;
        run_instr(3'd2, 1'b0, "add", mi, mr, ma, mp, mw, md);
        checks++;
        if (mi !== 8'b0001_0000 || mr !== 8'b1110_1110 || ma !== 8'b1000_0000) begin
            errors++;
            $display("FAIL add_masks: inc %b rd %b ldac %b, want 00010000 11101110 10000000", mi, mr, ma);
        end
    endtask

    task automatic test_jmp();
        logic [7:0] mi, mr, ma, mp, mw, md;
        run_instr(3'd7, 1'b1, "jmp", mi, mr, ma, mp, mw, md);
        checks++;
        if (mp !== 8'b1100_0000 || mi !== 8'b0001_0000 || mw !== 8'b0) begin
            errors++;
            $display("FAIL jmp_masks: ldpc %b inc %b wr %b, want 11000000 00010000 00000000", mp, mi, mw);
        end
    endtask

    task automatic test_skz();
        logic [7:0] mi, mr, ma, mp, mw, md;
        run_instr(3'd1, 1'b1, "skz1", mi, mr, ma, mp, mw, md);
        checks++;
        if (mi !== 8'b0101_0000) begin
            errors++;
            $display("FAIL skz_zero1: inc %b, want 01010000", mi);
        end
        run_instr(3'd1, 1'b0, "skz0", mi, mr, ma, mp, mw, md);
        checks++;
        if (mi !== 8'b0001_0000) begin
            errors++;
            $display("FAIL skz_zero0: inc %b, want 00010000", mi);
        end
    endtask

    task automatic test_sto();
        logic [7:0] mi, mr, ma, mp, mw, md;
        run_instr(3'd6, 1'b0, "sto", mi, mr, ma, mp, mw, md);
        checks++;
        if (md !== 8'b1100_0000 || mw !== 8'b1000_0000 || mr[7:5] !== 3'b000) begin
            errors++;
            $display("FAIL sto_masks: de %b wr %b rd %b, want 11000000 10000000 000xxxxx", md, mw, mr);
        end
    endtask

    task automatic test_hlt();
        do_reset();
        opcode = 3'd0;
        zero = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        #1;
        checks++;
        if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b1) begin
            errors++;
            $display("FAIL hlt_p4: phase %0d halt %b inc %b, want 4 1 1", phase, halt, inc_pc);
        end
        cycle();
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== 9'b000000001 || phase !== 3'd0 || !m_halt) begin
                errors++;
                $display("FAIL hlt_hold%0d: got %b phase %0d, want 000000001 phase 0", i, obs, phase);
            end
            cycle();
        end
`ifdef CTRL_RESUME_EN
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || halt !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL hlt_resume: phase %0d halt %b sel %b, want 0 0 1", phase, halt, sel);
        end
        cycle();
        #1;
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL hlt_resume_next: phase %0d, want 1", phase);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        opcode = 3'd5;
        zero = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL async_reach_p5: phase %0d, want 5", phase);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || sel !== 1'b1 || obs !== 9'b100000000) begin
            errors++;
            $display("FAIL async_reset_mid: phase %0d obs %b, want 0 100000000", phase, obs);
        end
        rst_n = 1'b1;
        m_phase = 0;
        m_halt = 0;
        cycle();
        #1;
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL async_restart: phase %0d, want 1", phase);
        end
    endtask

    task automatic test_random();
        int halted_for = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            opcode = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== exp_out(m_phase, m_halt, opcode, zero) ||
                phase !== (m_halt ? 3'd0 : 3'(m_phase)) || (ld_pc && inc_pc)) begin
                errors++;
                $display("FAIL rand%0d: op %0d z %b got %b phase %0d, want %b phase %0d", i,
                         opcode, zero, obs, phase, exp_out(m_phase, m_halt, opcode, zero),
                         m_halt ? 0 : m_phase);
            end
            halted_for = m_halt ? halted_for + 1 : 0;
            if (halted_for > 3 || $urandom_range(0, 49) == 0) begin
                do_reset();
                halted_for = 0;
            end
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef CTRL_RESUME_EN
        resume = 1'b0;
`endif
        opcode = 3'd2;
        zero = 1'b0;
        @(posedge clk);
        #2;
        test_reset();
        test_add();
        test_jmp();
        test_skz();
        test_sto();
        test_hlt();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
